// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier control unit.
//   - state_t   : controller state encoding
//   - WIDTH_DEF : default operand width
//   - ID_REQ0/1 : owner ids reported on done_id
//   - LAT_FIXED : grant-to-done cycles in the fixed-iteration build
package mult_pkg;
  localparam int   WIDTH_DEF = 8;
  localparam logic ID_REQ0   = 1'b0;
  localparam logic ID_REQ1   = 1'b1;
  localparam int   LAT_FIXED = 3 + 2*WIDTH_DEF;

  typedef enum logic [2:0] {
    S_IDLE, S_LOADB, S_LOADQ, S_TEST, S_SHIFT, S_DONE
  } state_t;
endpackage

// File: rtl/mult_seq_arbiter_if.sv
// Bus between the requesters/datapath and the multiplier control unit.
//   slave  : control-unit side (takes requests and datapath status, drives
//            grants, operand bus and datapath strobes)
//   master : requester/datapath side
interface mult_seq_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, busy, done, done_id;
  logic [WIDTH-1:0] opnd;
  logic             q0, z;
  logic [CNT_W-1:0] cnt_init;
  logic             load_b, load_q, reset_a, reset_c, load_p, load_a, shift, dec_c;

  modport slave (
    input  req0, a0, b0, req1, a1, b1, q0, z,
    output gnt0, gnt1, busy, done, done_id, opnd, cnt_init,
           load_b, load_q, reset_a, reset_c, load_p, load_a, shift, dec_c
  );

  modport master (
    output req0, a0, b0, req1, a1, b1, q0, z,
    input  gnt0, gnt1, busy, done, done_id, opnd, cnt_init,
           load_b, load_q, reset_a, reset_c, load_p, load_a, shift, dec_c
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset_n : clock, async active-low reset
//   i_req[1:0]   : request levels {req1, req0}
//   i_upd        : record i_upd_id as the last-served requester
//   o_win_id     : combinational winner among the active requests
// After reset the last-served pointer is requester 1, so requester 0 wins
// the first tie.
module rr_arb2
  import mult_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_id,
  output logic       o_win_id
);
  logic r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_last <= ID_REQ1;
    else if (i_upd) r_last <= i_upd_id;
  end

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    if (i_req == 2'b11) o_win_id = ~r_last;
    else if (i_req[1])  o_win_id = ID_REQ1;
    else                o_win_id = ID_REQ0;
  end
endmodule

// File: rtl/mult_seq_arbiter.sv
// Control unit and two-port arbiter for a shared shift-add multiplier
// datapath (A/Q shift registers, B register, adder, carry, down-counter).
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : requests/operands in, grants/done/done_id out, operand
//                  bus and datapath strobes out, q0/z status in
// Sequence: IDLE -> LOADB -> LOADQ -> (TEST -> SHIFT) x WIDTH -> DONE.
// Strobes, grants and done are decoded from the registered state.
// Optional macro MULT_SEQ_SKIP_EN: a zero multiplier bit is shifted in the
// TEST cycle itself, so it costs one cycle instead of two.
module mult_seq_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 4
)(
  input logic              clk,
  input logic              reset_n,
  mult_seq_arbiter_if.slave bus
);
  state_t     r_state;
  logic       r_owner;
  logic [1:0] w_req;
  logic       w_win;
  logic       w_busy;

  assign w_req = {bus.req1, bus.req0};

  rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (w_req),
    .i_upd    (r_state == S_DONE),
    .i_upd_id (r_owner),
    .o_win_id (w_win)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_owner <= ID_REQ0;
    end else begin
      case (r_state)
        S_IDLE: if (|w_req) begin
          r_owner <= w_win;
          r_state <= S_LOADB;
        end
        S_LOADB: r_state <= S_LOADQ;
        S_LOADQ: r_state <= S_TEST;
`ifdef MULT_SEQ_SKIP_EN
        // q0=0: the shift happens here, so z is evaluated here too.
        S_TEST:  if (bus.q0)     r_state <= S_SHIFT;
                 else if (bus.z) r_state <= S_DONE;
`else
        S_TEST:  r_state <= S_SHIFT;
`endif
        // z reflects the counter before this decrement: 0 means last shift.
        S_SHIFT: r_state <= bus.z ? S_DONE : S_TEST;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy       = (r_state != S_IDLE);
  assign bus.busy     = w_busy;
  assign bus.gnt0     = w_busy & (r_owner == ID_REQ0);
  assign bus.gnt1     = w_busy & (r_owner == ID_REQ1);
  assign bus.cnt_init = CNT_W'(WIDTH - 1);

  always_comb begin
    bus.opnd    = '0;
    bus.load_b  = 1'b0;
    bus.load_q  = 1'b0;
    bus.reset_a = 1'b0;
    bus.reset_c = 1'b0;
    bus.load_p  = 1'b0;
    bus.load_a  = 1'b0;
    bus.shift   = 1'b0;
    bus.dec_c   = 1'b0;
    bus.done    = 1'b0;
    bus.done_id = 1'b0;
    case (r_state)
      S_LOADB: begin
        bus.opnd   = r_owner ? bus.b1 : bus.b0;
        bus.load_b = 1'b1;
      end
      S_LOADQ: begin
        bus.opnd    = r_owner ? bus.a1 : bus.a0;
        bus.load_q  = 1'b1;
        bus.reset_a = 1'b1;
        bus.reset_c = 1'b1;
        bus.load_p  = 1'b1;
      end
      S_TEST: begin
        bus.load_a = bus.q0;
`ifdef MULT_SEQ_SKIP_EN
        bus.shift  = ~bus.q0;
        bus.dec_c  = ~bus.q0;
`endif
      end
      S_SHIFT: begin
        bus.shift = 1'b1;
        bus.dec_c = 1'b1;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.done_id = r_owner;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mult_seq_arbiter.sv
// Scoreboard bench for mult_seq_arbiter with a behavioural datapath model
// (A, Q, B, carry, down-counter) driven by the DUT strobes.
module tb_mult_seq_arbiter;
  localparam int W  = 8;
  localparam int CW = 4;

  typedef struct {
    logic        id;
    logic [15:0] prod;
    int          nla;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mult_seq_arbiter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  mult_seq_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- datapath model ----------------
  logic [W-1:0]  m_a = '0, m_q = '0, m_b = '0;
  logic          m_c = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  assign bus.q0 = m_q[0];
  assign bus.z  = (m_cnt == '0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.load_b)  m_b <= bus.opnd;
    if (bus.load_q)  m_q <= bus.opnd;
    if (bus.reset_a) m_a <= '0;
    if (bus.reset_c) m_c <= 1'b0;
    if (bus.load_p)  m_cnt <= bus.cnt_init;
    if (bus.load_a)  {m_c, m_a} <= {1'b0, m_a} + {1'b0, m_b};
    if (bus.shift) begin
      {m_a, m_q} <= {m_c, m_a, m_q[W-1:1]};
      m_c <= 1'b0;
    end
    if (bus.dec_c)   m_cnt <= m_cnt - 1'b1;
  end

  // ---------------- monitor ----------------
  int   st_cyc = 0;
  int   la_cnt = 0;
  logic prev_busy = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (bus.gnt0 && bus.gnt1) chk("grant_overlap", 1, 0);
    if (bus.busy && !prev_busy) begin
      st_cyc = cyc;
      la_cnt = 0;
    end
    if (bus.load_a) la_cnt++;
    prev_busy = bus.busy;
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_id", bus.done_id, e.id);
        chk("owner_gnt_at_done", e.id ? bus.gnt1 : bus.gnt0, 1);
        chk("product", {m_a, m_q}, e.prod);
        chk("load_a_pulses", la_cnt, e.nla);
        chk("grant_to_done", cyc - st_cyc + 1, e.lat);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int lat_of(input int nla);
`ifdef MULT_SEQ_SKIP_EN
    return 11 + nla;
`else
    return 19 + 0*nla;
`endif
  endfunction

  function automatic exp_t mk(input logic id, input logic [15:0] p, input int nla);
    exp_t x;
    x.id = id; x.prod = p; x.nla = nla; x.lat = lat_of(nla);
    return x;
  endfunction

  task automatic wait_done(input int n, input int budget);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (bus.done) seen++;
    end
    chk("done_within_budget", seen, n);
  endtask

  task automatic wait_gnt(input logic id);
    int k = 0;
    while (!(id ? bus.gnt1 : bus.gnt0) && k < 5) begin
      @(negedge clk);
      k++;
    end
    chk("grant_seen", id ? bus.gnt1 : bus.gnt0, 1);
  endtask

  function automatic longint outs();
    return {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.opnd,
            bus.load_b, bus.load_q, bus.reset_a, bus.reset_c, bus.load_p,
            bus.load_a, bus.shift, bus.dec_c};
  endfunction

  // One sole-requester operation; drop > 0 releases req that many cycles
  // after the grant, otherwise req is held until the done cycle.
  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] p, input int nla, input int drop);
    sb.push_back(mk(id, p, nla));
    @(negedge clk);
    if (id) begin bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1; end
    else    begin bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1; end
    wait_gnt(id);
    chk("loadb_first", bus.load_b, 1);
    chk("opnd_is_b", bus.opnd, b);
    if (drop > 0) begin
      repeat (drop) @(negedge clk);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
    end
    wait_done(1, 40);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("cnt_init", bus.cnt_init, 7);

    // Tie held over two operations: req0 first, then req1.
    sb.push_back(mk(1'b0, 16'd42, 2));
    sb.push_back(mk(1'b1, 16'd90, 2));
    bus.a0 = 8'd6; bus.b0 = 8'd7; bus.a1 = 8'd9; bus.b1 = 8'd10;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_done(2, 60);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);

    run_op(1'b0, 8'd13,  8'd11,  16'd143,   3, 0);
    run_op(1'b0, 8'd255, 8'd255, 16'd65025, 8, 0);
    run_op(1'b1, 8'd0,   8'd200, 16'd0,     0, 0);
    run_op(1'b0, 8'd7,   8'd9,   16'd63,    3, 5);

    // Reset in the SHIFT of the 4th iteration (all-ones multiplier keeps
    // the schedule identical in both builds: grant cycle 1, SHIFT at 10).
    @(negedge clk);
    bus.a1 = 8'd255; bus.b1 = 8'd3; bus.req1 = 1'b1;
    wait_gnt(1'b1);
    repeat (9) @(negedge clk);
    chk("shift_before_reset", bus.shift, 1);
    reset_n = 1'b0; bus.req1 = 1'b0;
    #1;
    chk("outputs_in_reset", outs(), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);

    run_op(1'b1, 8'd5, 8'd6, 16'd30, 2, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end
endmodule
